sequence_player: RTL and testbench

//  Consumes the 32-bit seed from the seed generator and plays the Simon colour sequence for the current round.

---
 rtl/sequence_player.sv | 112 +++++++++++
 tb/tb_sequence_player.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sequence_player.sv
// Plays the Simon colour sequence held in a latched 32-bit seed on four one-hot
// LEDs with fixed on/off timing, and offers random access to any step.
`default_nettype none

module sequence_player #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int MAX_STEPS  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] seed,
  input  logic        start,
  input  logic [4:0]  round,
  input  logic [3:0]  query_idx,
  output logic        busy,
  output logic        done,
  output logic [3:0]  led_onehot,
  output logic [1:0]  color,
  output logic        color_valid,
  output logic [1:0]  query_color
);

  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [31:0]   seed_q;
  logic [4:0]    round_q;
  logic [3:0]    step;
  logic [TW-1:0] timer;

  logic          on_last, off_last;
  logic [4:0]    step_plus;
  logic [4:0]    round_clamped;
  logic [1:0]    cur_color;

  assign on_last   = (timer == TW'(ON_CYCLES - 1));
  assign off_last  = (timer == TW'(OFF_CYCLES - 1));
  assign step_plus = {1'b0, step} + 5'd1;
  assign cur_color = seed_q[{step, 1'b0} +: 2];

  // Round 0 still plays one step; anything past the seed capacity is capped.
  always_comb begin
    round_clamped = round;
    if (round == 5'd0)
      round_clamped = 5'd1;
    else if (round > 5'(MAX_STEPS))
      round_clamped = 5'(MAX_STEPS);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = ON;
      ON:   if (on_last) state_next = OFF;
      OFF:  if (off_last) state_next = (step_plus < round_q) ? ON : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      seed_q  <= '0;
      round_q <= '0;
      step    <= '0;
      timer   <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          timer <= '0;
          if (start) begin
            seed_q  <= seed;
            round_q <= round_clamped;
            step    <= '0;
          end
        end
        ON: timer <= on_last ? '0 : timer + 1'b1;
        OFF: begin
          if (off_last) begin
            timer <= '0;
            if (state_next == ON) step <= step + 4'd1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: timer <= '0;
        default: timer <= '0;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign color_valid = (state == ON);
  assign color       = color_valid ? cur_color : 2'd0;
  assign led_onehot  = color_valid ? (4'b0001 << cur_color) : 4'b0000;
  assign query_color = seed_q[{query_idx, 1'b0} +: 2];

endmodule

`default_nettype wire

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player with ON_CYCLES=4, OFF_CYCLES=2.
`default_nettype none

module tb_sequence_player;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] seed;
  logic        start;
  logic [4:0]  round;
  logic [3:0]  query_idx;
  logic        busy, done, color_valid;
  logic [3:0]  led_onehot;
  logic [1:0]  color, query_color;

  int total = 0;
  int bad   = 0;

  sequence_player #(.ON_CYCLES(4), .OFF_CYCLES(2), .MAX_STEPS(16)) dut (
    .clk(clk), .reset(reset), .seed(seed), .start(start), .round(round),
    .query_idx(query_idx), .busy(busy), .done(done), .led_onehot(led_onehot),
    .color(color), .color_valid(color_valid), .query_color(query_color)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller has raised start for the accepting edge; this walks every cycle of
  // playback, the done pulse, and the idle cycle that follows it.
  // disturb: re-pulse start and scramble seed/round during step 1.
  // hold: keep start high throughout.
  task automatic check_play(input logic [31:0] sd, input int r,
                            input bit disturb, input bit hold);
    logic [1:0] c;
    for (int k = 0; k < r; k++) begin
      c = sd[2*k +: 2];
      for (int i = 0; i < 4; i++) begin
        tick();
        if (k == 0 && i == 0 && !hold) start = 1'b0;
        if (disturb && k == 1 && i == 1) begin
          start = 1'b0; seed = 32'h0; round = 5'd3;
        end
        chk("on_led",   {28'd0, led_onehot}, {28'd0, 4'b0001 << c});
        chk("on_color", {30'd0, color}, {30'd0, c});
        chk("on_valid", {31'd0, color_valid}, 32'd1);
        chk("on_busy",  {31'd0, busy}, 32'd1);
        chk("on_done",  {31'd0, done}, 32'd0);
        if (disturb && k == 1 && i == 0) begin
          start = 1'b1; seed = 32'hFFFF_FFFF; round = 5'd16;
        end
      end
      for (int i = 0; i < 2; i++) begin
        tick();
        chk("off_led",   {28'd0, led_onehot}, 32'd0);
        chk("off_valid", {31'd0, color_valid}, 32'd0);
        chk("off_busy",  {31'd0, busy}, 32'd1);
        chk("off_done",  {31'd0, done}, 32'd0);
      end
    end
    tick();
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_busy",  {31'd0, busy}, 32'd1);
    chk("done_led",   {28'd0, led_onehot}, 32'd0);
    tick();
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_led",  {28'd0, led_onehot}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; seed = 32'h0; start = 1'b0; round = 5'd0; query_idx = 4'd0;
    tick(); tick();
    reset = 1'b0;
    query_idx = 4'd5;
    #1;
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_led",   {28'd0, led_onehot}, 32'd0);
    chk("rst_color", {30'd0, color}, 32'd0);
    chk("rst_valid", {31'd0, color_valid}, 32'd0);
    chk("rst_query", {30'd0, query_color}, 32'd0);
    tick();

    // Scenario 1: three steps of E4E4E4E4 -> colours 0,1,2
    seed = 32'hE4E4_E4E4; round = 5'd3; start = 1'b1;
    check_play(32'hE4E4_E4E4, 3, 1'b0, 1'b0);

    // Scenario 5: random-access lookup after playback
    query_idx = 4'd0;  #1; chk("q0",  {30'd0, query_color}, 32'd0);
    query_idx = 4'd1;  #1; chk("q1",  {30'd0, query_color}, 32'd1);
    query_idx = 4'd2;  #1; chk("q2",  {30'd0, query_color}, 32'd2);
    query_idx = 4'd3;  #1; chk("q3",  {30'd0, query_color}, 32'd3);
    query_idx = 4'd15; #1; chk("q15", {30'd0, query_color}, 32'd3);
    tick();

    // Scenario 2: round clamping
    seed = 32'h0; round = 5'd0; start = 1'b1;
    check_play(32'h0, 1, 1'b0, 1'b0);
    round = 5'd20; start = 1'b1;
    check_play(32'h0, 16, 1'b0, 1'b0);

    // Scenario 3: start/seed/round disturbed mid-playback
    seed = 32'hE4E4_E4E4; round = 5'd3; start = 1'b1;
    check_play(32'hE4E4_E4E4, 3, 1'b1, 1'b0);

    // Scenario 4: reset in cycle t+6
    seed = 32'hE4E4_E4E4; round = 5'd3; start = 1'b1; query_idx = 4'd1;
    tick(); start = 1'b0;
    for (int i = 2; i <= 6; i++) tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    chk("mid_rst_led",   {28'd0, led_onehot}, 32'd0);
    chk("mid_rst_query", {30'd0, query_color}, 32'd0);
    chk("mid_rst_done",  {31'd0, done}, 32'd0);
    tick();
    seed = 32'h0000_001B; round = 5'd3; start = 1'b1;
    check_play(32'h0000_001B, 3, 1'b0, 1'b0);

    // Scenario 6: start held high -> back-to-back playbacks
    seed = 32'h0000_0003; round = 5'd1; start = 1'b1;
    check_play(32'h0000_0003, 1, 1'b0, 1'b1);
    check_play(32'h0000_0003, 1, 1'b0, 1'b0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
